// File: rtl/idelay_sweep_ctrl.sv
// idelay_sweep_ctrl: steps one delay cell through a tap range, counts probe ones per point, streams records.
// Optional build macro SWEEP_TIMEOUT_EN: give up on a missing dly_done after TIMEOUT cycles.
module idelay_sweep_ctrl #(
    parameter int DWELL_W = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [8:0]         cfg_first,
    input  logic [8:0]         cfg_last,
    input  logic [8:0]         cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic               busy,
    output logic               sweep_done,
    output logic               err_timeout,
    output logic               dly_change,
    output logic               dly_read,
    output logic [8:0]         dly_value,
    input  logic               dly_done,
    input  logic [8:0]         dly_readback,
    input  logic               probe,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [8:0]         res_tap,
    output logic [8:0]         res_readback,
    output logic [DWELL_W-1:0] res_ones
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET,
        S_WAIT_SET,
        S_DWELL,
        S_RDREQ,
        S_WAIT_RD,
        S_EMIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [8:0]         r_tap;
    logic [8:0]         r_last;
    logic [8:0]         r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] r_ones;
    logic               r_abort_pend;
    logic               r_busy;
    logic               r_sweep_done;
    logic               r_err;
    logic               r_dly_change;
    logic               r_dly_read;
    logic               r_res_valid;
    logic [8:0]         r_res_tap;
    logic [8:0]         r_res_rb;
    logic [9:0]         w_nxt;
    logic               w_abort_any;
    logic               w_tmo_expired;
    logic               w_tmo_hit;

    assign w_abort_any = r_abort_pend | abort;
    // Ten bits so a step past 511 is seen as an overrun rather than wrapping to a low tap.
    assign w_nxt       = {1'b0, r_tap} + {1'b0, r_step};

`ifdef SWEEP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_tmo_expired = (r_tmo_cnt == TMO_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_SET || r_state == S_RDREQ) begin
            r_tmo_cnt <= TMO_W'(TIMEOUT - 1);
        end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
        end
    end
`else
    assign w_tmo_expired = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_tmo_hit = 1'b0;
        unique case (r_state)
            S_IDLE:     if (start) w_next = S_SET;
            S_SET:      w_next = S_WAIT_SET;
            S_WAIT_SET: begin
                if (dly_done) begin
                    w_next = w_abort_any ? S_FINISH : S_DWELL;
                end else if (w_tmo_expired) begin
                    w_next    = S_FINISH;
                    w_tmo_hit = 1'b1;
                end
            end
            S_DWELL:    if (r_dwell_cnt <= DWELL_W'(1)) w_next = S_RDREQ;
            S_RDREQ:    w_next = S_WAIT_RD;
            S_WAIT_RD: begin
                if (dly_done) begin
                    w_next = w_abort_any ? S_FINISH : S_EMIT;
                end else if (w_tmo_expired) begin
                    w_next    = S_FINISH;
                    w_tmo_hit = 1'b1;
                end
            end
            S_EMIT:     if (res_ready || abort) w_next = w_abort_any ? S_FINISH : S_NEXT;
            S_NEXT:     w_next = (w_nxt[9] || (w_nxt > {1'b0, r_last})) ? S_FINISH : S_SET;
            S_FINISH:   w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tap        <= '0;
            r_last       <= '0;
            r_step       <= '0;
            r_dwell      <= '0;
            r_dwell_cnt  <= '0;
            r_ones       <= '0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
            r_err        <= 1'b0;
            r_dly_change <= 1'b0;
            r_dly_read   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_tap    <= '0;
            r_res_rb     <= '0;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next != S_IDLE);
            r_sweep_done <= (w_next == S_FINISH);
            r_dly_change <= (w_next == S_SET);
            r_dly_read   <= (w_next == S_RDREQ);
            r_res_valid  <= (w_next == S_EMIT);

            if (r_state == S_IDLE) begin
                r_abort_pend <= 1'b0;
                if (start) begin
                    r_tap   <= cfg_first;
                    r_last  <= cfg_last;
                    r_step  <= (cfg_step == 9'd0) ? 9'd1 : cfg_step;
                    r_dwell <= cfg_dwell;
                    r_err   <= 1'b0;
                end
            end else if (abort) begin
                r_abort_pend <= 1'b1;
            end

            if (w_tmo_hit) r_err <= 1'b1;

            if (r_state == S_DWELL) begin
                if (r_dwell_cnt != '0) r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                if (probe && (r_dwell != '0)) r_ones <= r_ones + DWELL_W'(1);
            end else if (w_next == S_DWELL) begin
                r_dwell_cnt <= r_dwell;
                r_ones      <= '0;
            end

            if (r_state == S_WAIT_RD && dly_done) begin
                r_res_tap <= r_tap;
                r_res_rb  <= dly_readback;
            end

            if (r_state == S_NEXT && w_next == S_SET) r_tap <= w_nxt[8:0];
        end
    end

    assign busy         = r_busy;
    assign sweep_done   = r_sweep_done;
    assign err_timeout  = r_err;
    assign dly_change   = r_dly_change;
    assign dly_read     = r_dly_read;
    assign dly_value    = r_tap;
    assign res_valid    = r_res_valid;
    assign res_tap      = r_res_tap;
    assign res_readback = r_res_rb;
    assign res_ones     = r_ones;

endmodule

// File: tb/tb_idelay_sweep_ctrl.sv
// Self-checking bench for idelay_sweep_ctrl: delay-cell model, probe window model and tap-list model.
// Define SWEEP_TIMEOUT_EN for both files to exercise the timeout path.
module tb_idelay_sweep_ctrl;
    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [8:0]    cfg_first = '0, cfg_last = '0, cfg_step = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          busy, sweep_done, err_timeout, dly_change, dly_read;
    logic [8:0]    dly_value;
    logic          dly_done = 1'b0;
    logic [8:0]    dly_readback = '0;
    logic          probe = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [8:0]    res_tap, res_readback;
    logic [DW-1:0] res_ones;

    idelay_sweep_ctrl #(.DWELL_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_first(cfg_first), .cfg_last(cfg_last), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
        .busy(busy), .sweep_done(sweep_done), .err_timeout(err_timeout),
        .dly_change(dly_change), .dly_read(dly_read), .dly_value(dly_value),
        .dly_done(dly_done), .dly_readback(dly_readback), .probe(probe),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_tap(res_tap), .res_readback(res_readback), .res_ones(res_ones)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus knobs, written only by the main process.
    int c_first, c_last, c_step, c_dwell;
    int pmode = 1, rb_off = 0, lat = 20;
    bit cell_never = 0, early_end = 0;
    int bp_idx = -1, bp_len = 0;
    int sweep_id = 0;

    // Delay cell: answers each request lat cycles later; readback is the stored tap plus rb_off.
    int t_dchg = 0, t_dread = 0;
    bit done_is_chg = 0;
    int cell_cnt = 0, cell_val = 0;
    bit cell_kind_chg = 0;
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                dly_done = 0; done_is_chg = 0; cell_cnt = 0; cell_val = 0; dly_readback = '0;
                continue;
            end
            #1;
            dly_done = 0;
            done_is_chg = 0;
            if (cell_cnt > 0) begin
                cell_cnt--;
                if (cell_cnt == 0) begin
                    dly_done = 1;
                    done_is_chg = cell_kind_chg;
                    if (cell_kind_chg) t_dchg = cyc; else t_dread = cyc;
                end
            end
            if (dly_change) begin cell_val = int'(dly_value); cell_kind_chg = 1; cell_cnt = cell_never ? 0 : lat; end
            if (dly_read)   begin cell_kind_chg = 0; cell_cnt = cell_never ? 0 : lat; end
            dly_readback = 9'((cell_val + rb_off) % 512);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        probe = (pmode == 2) ? 1'($urandom_range(0, 1)) : 1'(pmode);
    end

    int bp_hold = 0, rdy_seen_id = 0;
    int rec_cnt = 0;
    initial forever begin
        @(posedge clk); #1;
        if (rdy_seen_id != sweep_id) begin rdy_seen_id = sweep_id; bp_hold = 0; end
        if (res_valid && rec_cnt == bp_idx && bp_hold < bp_len) begin
            res_ready = 0; bp_hold++;
        end else res_ready = 1;
    end

    // Model and compare process.
    int exp_q[$];
    int got_tap[$], got_ones[$];
    int n_exp = 0, chg_cnt = 0, rd_cnt = 0, n_sd = 0;
    int hs_cyc = -1, t_chg = 0, t_sd = 0, vstart = 0, bp_dur = -1;
    int win_left = 0, win_acc = 0, last_ones = 0, cmp_seen_id = 0;
    bit prev_valid = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 0; win_left = 0;
        end else begin
            if (cmp_seen_id != sweep_id) begin
                int t, n;
                cmp_seen_id = sweep_id;
                exp_q.delete(); got_tap.delete(); got_ones.delete();
                t = c_first;
                forever begin
                    exp_q.push_back(t);
                    n = t + ((c_step == 0) ? 1 : c_step);
                    if (n > c_last || n > 511) break;
                    t = n;
                end
                n_exp = exp_q.size();
                rec_cnt = 0; chg_cnt = 0; rd_cnt = 0; hs_cyc = -1; bp_dur = -1;
            end
            if (win_left > 0) begin
                win_acc += int'(probe); win_left--;
                if (win_left == 0) last_ones = win_acc;
            end
            if (dly_done && done_is_chg) begin
                win_left = c_dwell; win_acc = 0;
                if (c_dwell == 0) last_ones = 0;
            end
            if (res_valid) begin
                if (!prev_valid) begin vstart = cyc; chk("valid_latency", cyc, t_dread + 1); end
                chk("record_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("res_tap", res_tap, exp_q[0]);
                    chk("res_readback", res_readback, (exp_q[0] + rb_off) % 512);
                    chk("res_ones", res_ones, last_ones);
                end
                if (res_ready) begin
                    got_tap.push_back(int'(res_tap)); got_ones.push_back(int'(res_ones));
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (rec_cnt == bp_idx) bp_dur = cyc - vstart;
                    hs_cyc = cyc; rec_cnt++;
                end
            end
            prev_valid = res_valid;
            if (dly_change) begin
                chg_cnt++; t_chg = cyc;
                if (exp_q.size() > 0) chk("dly_value", dly_value, exp_q[0]);
                if (hs_cyc >= 0) chk("change_after_handshake", cyc, hs_cyc + 2);
            end
            if (dly_read) begin
                rd_cnt++;
                chk("read_latency", cyc, t_dchg + 1 + ((c_dwell > 1) ? c_dwell : 1));
            end
            if (sweep_done) begin
                n_sd++; t_sd = cyc;
`ifndef SWEEP_TIMEOUT_EN
                chk("err_timeout_tied", err_timeout, 0);
`endif
                if (!early_end) begin
                    chk("records_left", exp_q.size(), 0);
                    chk("done_after_handshake", cyc, hs_cyc + 2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic setup(input int f, input int l, input int s, input int d,
                         input int pm, input int rb, input int lt);
        c_first = f; c_last = l; c_step = s; c_dwell = d;
        pmode = pm; rb_off = rb; lat = lt;
        cfg_first = 9'(f); cfg_last = 9'(l); cfg_step = 9'(s); cfg_dwell = DW'(d);
        sweep_id++;
    endtask

    task automatic kick();
        tick();
        start = 1;
        tick();
        start = 0;
        @(negedge clk);
        chk("busy_at_cycle1", busy, 1);
        chk("change_at_cycle1", dly_change, 1);
    endtask

    task automatic wait_done(input int budget, input int abort_rec);
        int n0 = n_sd;
        bit ok = 0, aborted = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (n_sd != n0) begin ok = 1; break; end
            if (abort_rec >= 0 && !aborted && chg_cnt == abort_rec + 1 && cyc == t_chg + 3) begin
                aborted = 1;
                tick(); abort = 1;
                tick(); abort = 0;
            end
        end
        chk("sweep_done_seen", ok, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        int lit_basic[4] = '{0, 10, 20, 30};
        int lit_wrap[2]  = '{500, 508};
        int lit_step0[3] = '{5, 6, 7};
        int lit_dw0[2]   = '{100, 120};

        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);          chk("rst_sweep_done", sweep_done, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_dly_change", dly_change, 0); chk("rst_dly_read", dly_read, 0);
        chk("rst_dly_value", dly_value, 0); chk("rst_res_valid", res_valid, 0);
        chk("rst_res_tap", res_tap, 0);     chk("rst_res_readback", res_readback, 0);
        chk("rst_res_ones", res_ones, 0);
        rst_n = 1;

        // abort while idle must not start anything
        tick(); abort = 1; tick(); abort = 0;
        @(negedge clk); chk("idle_abort_busy", busy, 0);

        setup(0, 30, 10, 8, 1, 0, 20); kick(); wait_done(5000, -1);
        chk("basic_n", got_tap.size(), 4);
        for (int i = 0; i < got_tap.size() && i < 4; i++) begin
            chk("basic_tap", got_tap[i], lit_basic[i]);
            chk("basic_ones", got_ones[i], 8);
        end

        setup(500, 511, 8, 4, 2, 0, 5); kick(); wait_done(5000, -1);
        chk("wrap_n", got_tap.size(), 2);
        for (int i = 0; i < got_tap.size() && i < 2; i++) chk("wrap_tap", got_tap[i], lit_wrap[i]);

        setup(5, 7, 0, 13, 2, 3, 3); kick(); wait_done(5000, -1);
        chk("step0_n", got_tap.size(), 3);
        for (int i = 0; i < got_tap.size() && i < 3; i++) chk("step0_tap", got_tap[i], lit_step0[i]);

        setup(100, 120, 20, 0, 1, 0, 4); kick(); wait_done(5000, -1);
        chk("dwell0_n", got_tap.size(), 2);
        for (int i = 0; i < got_tap.size() && i < 2; i++) begin
            chk("dwell0_tap", got_tap[i], lit_dw0[i]);
            chk("dwell0_ones", got_ones[i], 0);
        end

        bp_idx = 1; bp_len = 50;
        setup(0, 30, 10, 8, 2, 0, 20); kick(); wait_done(5000, -1);
        chk("bp_n", got_tap.size(), 4);
        chk("bp_hold_cycles", bp_dur, 50);
        bp_idx = -1; bp_len = 0;

        early_end = 1;
        setup(0, 30, 10, 8, 1, 0, 20); kick(); wait_done(5000, 1);
        chk("abort_n", got_tap.size(), 1);
        chk("abort_reads", rd_cnt, 1);
        chk("abort_done_after_cell", t_sd, t_dchg + 1);

        setup(0, 30, 10, 8, 1, 0, 20); kick();
        repeat (30) @(negedge clk);
        rst_n = 0; #1;
        chk("midrst_busy", busy, 0); chk("midrst_valid", res_valid, 0);
        chk("midrst_dly_value", dly_value, 0);
        @(negedge clk); rst_n = 1;
        early_end = 0;

        setup(9, 3, 4, 6, 1, 0, 2); kick(); wait_done(5000, -1);
        chk("single_n", got_tap.size(), 1);
        if (got_tap.size() > 0) begin
            chk("single_tap", got_tap[0], 9);
            chk("single_ones", got_ones[0], 6);
        end

`ifdef SWEEP_TIMEOUT_EN
        early_end = 1; cell_never = 1;
        setup(50, 60, 5, 2, 1, 0, 20); kick();
        wait_done(500, -1);
        chk("tmo_done_cycle", t_sd, t_chg + 15);
        chk("tmo_err_held", err_timeout, 1);
        early_end = 0; cell_never = 0;
        setup(50, 60, 5, 2, 1, 0, 6); kick();
        chk("tmo_err_cleared", err_timeout, 0);
        wait_done(5000, -1);
        chk("tmo_recover_n", got_tap.size(), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end
endmodule
